// File: rtl/store_data_aligner.sv
`default_nettype none
// ============================================================================
// Module      : store_data_aligner
// Description : RV32I store aligner. Places SB/SH/SW data on the correct byte
//               lanes of a word-aligned data-memory bus, generates byte
//               enables, and splits word-crossing stores into two beats.
// Revision    : 1.0 - initial release
// ============================================================================
module store_data_aligner #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   output logic        mem_valid_o,
   input  logic        mem_ready_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BEAT0 = 2'd1;
   localparam logic [1:0] c_BEAT1 = 2'd2;

   localparam logic [2:0] c_F3_SB = 3'b000;
   localparam logic [2:0] c_F3_SH = 3'b001;
   localparam logic [2:0] c_F3_SW = 3'b010;

   logic [1:0]  r_state;
   logic        r_mem_valid;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_be;
   logic        r_done;
   logic        r_err;
   logic        r_split;
   logic [31:0] r_b1_addr;
   logic [31:0] r_b1_wdata;
   logic [3:0]  r_b1_be;

   logic        w_accept;
   logic        w_legal;
   logic [31:0] w_masked;
   logic [3:0]  w_base_be;
   logic [63:0] w_shift_data;
   logic [7:0]  w_shift_be;
   logic        w_split;
   logic [31:0] w_b0_addr;
   logic [31:0] w_b1_addr;

   // Ready only when idle and out of reset, so nothing is accepted mid-store.
   assign req_ready_o = (r_state == c_IDLE) && rst_ni;
   assign w_accept    = req_valid_i && req_ready_o;

   // Size masking and lane shifting of the incoming request.
   always_comb begin
      w_legal   = 1'b1;
      w_masked  = wdata_i;
      w_base_be = 4'b1111;
      case (funct3_i)
         c_F3_SB: begin
            w_masked  = {24'd0, wdata_i[7:0]};
            w_base_be = 4'b0001;
         end
         c_F3_SH: begin
            w_masked  = {16'd0, wdata_i[15:0]};
            w_base_be = 4'b0011;
         end
         c_F3_SW: begin
            w_masked  = wdata_i;
            w_base_be = 4'b1111;
         end
         default: begin
            w_legal   = 1'b0;
            w_masked  = wdata_i;
            w_base_be = 4'b1111;
         end
      endcase
      w_shift_data = {32'd0, w_masked} << {addr_i[1:0], 3'b000};
      w_shift_be   = {4'd0, w_base_be} << addr_i[1:0];
      w_split      = |w_shift_be[7:4];
      w_b0_addr    = {addr_i[31:2], 2'b00};
      w_b1_addr    = w_b0_addr + 32'd4;
   end

   // Store sequencer: accept, issue one or two beats, then signal completion.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state     <= c_IDLE;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_mem_be    <= 4'd0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_split     <= 1'b0;
         r_b1_addr   <= 32'd0;
         r_b1_wdata  <= 32'd0;
         r_b1_be     <= 4'd0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  if (!w_legal || (w_split && !ALLOW_MISALIGNED)) begin
                     // Rejected: no bus access, just report.
                     r_err  <= 1'b1;
                     r_done <= 1'b1;
                  end else begin
                     r_state     <= c_BEAT0;
                     r_mem_valid <= 1'b1;
                     r_mem_addr  <= w_b0_addr;
                     r_mem_wdata <= w_shift_data[31:0];
                     r_mem_be    <= w_shift_be[3:0];
                     r_split     <= w_split;
                     r_b1_addr   <= w_b1_addr;
                     r_b1_wdata  <= w_shift_data[63:32];
                     r_b1_be     <= w_shift_be[7:4];
                  end
               end
            end
            c_BEAT0: begin
               if (mem_ready_i) begin
                  if (r_split) begin
                     r_state     <= c_BEAT1;
                     r_mem_addr  <= r_b1_addr;
                     r_mem_wdata <= r_b1_wdata;
                     r_mem_be    <= r_b1_be;
                  end else begin
                     r_state     <= c_IDLE;
                     r_mem_valid <= 1'b0;
                     r_mem_addr  <= 32'd0;
                     r_mem_wdata <= 32'd0;
                     r_mem_be    <= 4'd0;
                     r_done      <= 1'b1;
                  end
               end
            end
            c_BEAT1: begin
               if (mem_ready_i) begin
                  r_state     <= c_IDLE;
                  r_mem_valid <= 1'b0;
                  r_mem_addr  <= 32'd0;
                  r_mem_wdata <= 32'd0;
                  r_mem_be    <= 4'd0;
                  r_done      <= 1'b1;
               end
            end
            default: begin
               r_state     <= c_IDLE;
               r_mem_valid <= 1'b0;
               r_mem_addr  <= 32'd0;
               r_mem_wdata <= 32'd0;
               r_mem_be    <= 4'd0;
            end
         endcase
      end
   end

   assign mem_valid_o = r_mem_valid;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_be_o    = r_mem_be;
   assign done_o      = r_done;
   assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_data_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_data_aligner
// Description : Directed self-checking bench for store_data_aligner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_data_aligner;

   logic        clk;
   logic        rst_ni;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  funct3;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        done;
   logic        err;

   // Second instance with misaligned stores disallowed
   logic        na_req_valid;
   logic        na_req_ready;
   logic        na_mem_ready;
   logic        na_mem_valid;
   logic [31:0] na_mem_addr;
   logic [31:0] na_mem_wdata;
   logic [3:0]  na_mem_be;
   logic        na_done;
   logic        na_err;

   int vectors;
   int miscompares;

   store_data_aligner #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .funct3_i    (funct3),
      .mem_valid_o (mem_valid),
      .mem_ready_i (mem_ready),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .done_o      (done),
      .err_o       (err)
   );

   store_data_aligner #(.ALLOW_MISALIGNED(1'b0)) dut_na (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (na_req_valid),
      .req_ready_o (na_req_ready),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .funct3_i    (funct3),
      .mem_valid_o (na_mem_valid),
      .mem_ready_i (na_mem_ready),
      .mem_addr_o  (na_mem_addr),
      .mem_wdata_o (na_mem_wdata),
      .mem_be_o    (na_mem_be),
      .done_o      (na_done),
      .err_o       (na_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request to the main instance; returns 1 time unit after the acceptance edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      addr      = a;
      wdata     = d;
      funct3    = f;
      req_valid = 1'b1;
      #1;
      chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
      chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
      chk({tag, "_addr"},  mem_addr, a);
      chk({tag, "_be"},    {28'd0, mem_be}, {28'd0, be});
      chk({tag, "_wdata"}, mem_wdata, d);
      chk({tag, "_done"},  {31'd0, done}, 32'd0);
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd0);
   endtask

   task automatic chk_done(input string tag);
      chk({tag, "_done"},  {31'd0, done}, 32'd1);
      chk({tag, "_err"},   {31'd0, err}, 32'd0);
      chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
      chk({tag, "_addr0"}, mem_addr, 32'd0);
      chk({tag, "_be0"},   {28'd0, mem_be}, 32'd0);
      chk({tag, "_wd0"},   mem_wdata, 32'd0);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_ni       = 1'b0;
      req_valid    = 1'b0;
      na_req_valid = 1'b0;
      na_mem_ready = 1'b1;
      mem_ready    = 1'b1;
      addr         = 32'd0;
      wdata        = 32'd0;
      funct3       = 3'b000;

      // Reset state
      step();
      step();
      chk("rst_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_done",  {31'd0, done}, 32'd0);
      chk("rst_err",   {31'd0, err}, 32'd0);
      chk("rst_addr",  mem_addr, 32'd0);
      chk("rst_be",    {28'd0, mem_be}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_ni = 1'b1;
      #1;
      chk("rel_ready", {31'd0, req_ready}, 32'd1);
      step();

      // Aligned SW: beat at N+1, done at N+2
      issue(32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
      chk_beat("sw", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
      step();
      chk_done("sw");

      // SB at byte 3, then SH accepted in the cycle done pulses
      step();
      issue(32'h0000_0203, 32'h1234_56AB, 3'b000);
      chk_beat("sb", 32'h0000_0200, 4'b1000, 32'hAB00_0000);
      step();
      chk_done("sb");
      issue(32'h0000_0302, 32'hCAFE_1234, 3'b001);
      chk_beat("sh", 32'h0000_0300, 4'b1100, 32'h1234_0000);
      step();
      chk_done("sh");

      // Word-crossing SW: beats at N+1 and N+2, done at N+3
      step();
      issue(32'h0000_0401, 32'h1122_3344, 3'b010);
      chk_beat("split_b0", 32'h0000_0400, 4'b1110, 32'h2233_4400);
      step();
      chk_beat("split_b1", 32'h0000_0404, 4'b0001, 32'h0000_0011);
      step();
      chk_done("split");

      // Wrapping SH with backpressure in BEAT0
      step();
      mem_ready = 1'b0;
      issue(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001);
      chk_beat("wrap_b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_beat("wrap_hold", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
      end
      mem_ready = 1'b1;
      step();
      chk_beat("wrap_b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
      step();
      chk_done("wrap");

      // Illegal funct3: err+done at N+1, no beat
      step();
      issue(32'h0000_0500, 32'h5555_5555, 3'b011);
      chk("ill_err",   {31'd0, err}, 32'd1);
      chk("ill_done",  {31'd0, done}, 32'd1);
      chk("ill_valid", {31'd0, mem_valid}, 32'd0);
      chk("ill_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("ill_err_clr",  {31'd0, err}, 32'd0);
      chk("ill_valid2",   {31'd0, mem_valid}, 32'd0);

      // ALLOW_MISALIGNED=0: crossing SW rejected
      addr         = 32'h0000_0002;
      wdata        = 32'hA5A5_A5A5;
      funct3       = 3'b010;
      na_req_valid = 1'b1;
      #1;
      chk("na_ready", {31'd0, na_req_ready}, 32'd1);
      step();
      na_req_valid = 1'b0;
      chk("na_err",   {31'd0, na_err}, 32'd1);
      chk("na_done",  {31'd0, na_done}, 32'd1);
      chk("na_valid", {31'd0, na_mem_valid}, 32'd0);
      step();
      chk("na_valid2", {31'd0, na_mem_valid}, 32'd0);
      chk("na_err_clr", {31'd0, na_err}, 32'd0);

      // ALLOW_MISALIGNED=0: aligned SW still goes through
      addr         = 32'h0000_0010;
      wdata        = 32'h0BAD_F00D;
      na_req_valid = 1'b1;
      step();
      na_req_valid = 1'b0;
      chk("na_ok_valid", {31'd0, na_mem_valid}, 32'd1);
      chk("na_ok_addr",  na_mem_addr, 32'h0000_0010);
      chk("na_ok_be",    {28'd0, na_mem_be}, 32'h0000_000F);
      chk("na_ok_err",   {31'd0, na_err}, 32'd0);
      step();
      chk("na_ok_done",  {31'd0, na_done}, 32'd1);

      // Reset during BEAT0 abandons the store
      step();
      mem_ready = 1'b0;
      issue(32'h0000_0600, 32'h7777_8888, 3'b010);
      chk_beat("rstmid_b0", 32'h0000_0600, 4'b1111, 32'h7777_8888);
      rst_ni = 1'b0;
      step();
      chk("rstmid_valid", {31'd0, mem_valid}, 32'd0);
      chk("rstmid_done",  {31'd0, done}, 32'd0);
      chk("rstmid_ready", {31'd0, req_ready}, 32'd0);
      mem_ready = 1'b1;
      rst_ni    = 1'b1;
      #1;
      chk("rstmid_ready_rel", {31'd0, req_ready}, 32'd1);
      step();
      chk("rstmid_no_done", {31'd0, done}, 32'd0);
      chk("rstmid_valid2",  {31'd0, mem_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/store_data_aligner.md
Name: store_data_aligner

Overview:
- Store-side counterpart of the load path: takes an RV32I store (SB/SH/SW) from the execute stage and drives byte-enabled, word-aligned writes to the data-memory bus.
- Shifts write data onto the correct byte lanes and generates byte enables.
- A store that crosses a word boundary is split into two bus beats under a valid/ready handshake.
- Sits between the execute/memory stage and the data-memory port.

Parameters:
- ALLOW_MISALIGNED, 1: when 1, word-crossing stores are split into two beats; when 0, they are rejected via err_o with no bus access.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  synchronous active-low reset
- req_valid_i  input  1  store request valid
- req_ready_o  output  1  aligner can accept a request
- addr_i  input  32  byte address of store
- wdata_i  input  32  store data, LSB-justified
- funct3_i  input  3  000 SB, 001 SH, 010 SW; all other codes are illegal
- mem_valid_o  output  1  bus beat valid
- mem_ready_i  input  1  memory accepts beat
- mem_addr_o  output  32  word-aligned address, bits [1:0] always 0
- mem_wdata_o  output  32  lane-shifted data, unused lanes 0
- mem_be_o  output  4  byte enables
- done_o  output  1  one-cycle pulse: store complete
- err_o  output  1  one-cycle pulse: illegal funct3, or misaligned store when ALLOW_MISALIGNED=0

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values:
  - State IDLE.
  - mem_valid_o=0, done_o=0, err_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
  - req_ready_o=0 while rst_ni=0.
- States: IDLE, BEAT0, BEAT1.
- req_ready_o = (state==IDLE) and rst_ni. Acceptance occurs on req_valid_i and req_ready_o. addr_i, wdata_i and funct3_i are registered on acceptance.
- Lane computation:
  - off = addr[1:0].
  - Data is masked to its size (SB bits 7:0, SH bits 15:0, SW all 32).
  - 64-bit shifted data = masked data << (8*off).
  - 8-bit enable = base << off, where base is 0001 / 0011 / 1111 for SB / SH / SW.
  - Beat0: addr {addr[31:2],2'b00}, data bits [31:0], enables [3:0].
  - Beat1: beat0 address + 4 (wraps mod 2^32), data bits [63:32], enables [7:4].
  - A split is needed iff enables [7:4] are nonzero.
- Transitions from IDLE after acceptance:
  - Illegal funct3, or split needed with ALLOW_MISALIGNED=0: stay IDLE. err_o and done_o pulse in the next cycle. No bus beat is issued.
  - Otherwise: go to BEAT0. mem_valid_o=1 from the next cycle.
- BEAT0 and BEAT1:
  - mem_valid_o held high.
  - mem_addr_o, mem_wdata_o and mem_be_o held stable until mem_ready_i is high.
  - Handshake in BEAT0: go to BEAT1 if a split is needed, else go to IDLE and pulse done_o the next cycle.
  - Handshake in BEAT1: go to IDLE and pulse done_o the next cycle.
- Latency with mem_ready_i tied high (acceptance at cycle N):
  - Aligned store: beat at N+1, done_o at N+2.
  - Split store: beats at N+1 and N+2, done_o at N+3.
- A new request may be accepted in the same cycle done_o pulses, because the block is already IDLE.
- Bus outputs are zero whenever mem_valid_o=0.
- Reset mid-operation: the in-flight store is abandoned. mem_valid_o=0 from the next cycle. No done_o is issued.
- Back-to-back acceptances are never lost. req_ready_o stays 0 throughout both beats.

Test Plan:
- SW addr 0x100 wdata 0xDEADBEEF, mem_ready_i=1 -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF. done_o at N+2.
- SB addr 0x203 wdata 0x123456AB -> addr 0x200, be 1000, wdata 0xAB000000. SH addr 0x302 wdata 0xCAFE1234 -> addr 0x300, be 1100, wdata 0x12340000.
- SW addr 0x401 wdata 0x11223344 -> beat0: addr 0x400, be 1110, wdata 0x22334400. beat1: addr 0x404, be 0001, wdata 0x00000011. done_o at N+3.
- SH addr 0xFFFFFFFF wdata 0x0000BEEF, mem_ready_i low for 3 cycles in BEAT0 -> beat0 held stable: addr 0xFFFFFFFC, be 1000, wdata 0xEF000000. beat1: addr 0x00000000, be 0001, wdata 0x000000BE.
- funct3 3'b011 -> err_o and done_o pulse at N+1, mem_valid_o never asserts. With ALLOW_MISALIGNED=0, SW addr 0x002 -> same response.
- rst_ni driven low during BEAT0 -> mem_valid_o=0 next cycle, no done_o. req_ready_o=1 after release.
